// File: rtl/clock_set_ctrl.sv
// Time/alarm setting controller: edits hours and minutes in BCD via three buttons,
// then strobes the result into the clock unit or the alarm shadow register.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic [3:0] cur_hr_t,
    input  logic [3:0] cur_hr_o,
    input  logic [3:0] cur_min_t,
    input  logic [3:0] cur_min_o,
    output logic [3:0] hr_t,
    output logic [3:0] hr_o,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       time_ow,
    output logic       alarm_ld,
    output logic [2:0] mode
);

    // state | meaning
    // IDLE  | not editing; bus holds last edited value
    // T_HR  | editing clock hours
    // T_MIN | editing clock minutes; mode commits with time_ow
    // A_HR  | editing alarm hours
    // A_MIN | editing alarm minutes; mode commits with alarm_ld
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        T_HR  = 3'd1,
        T_MIN = 3'd2,
        A_HR  = 3'd3,
        A_MIN = 3'd4
    } state_t;

    localparam logic [15:0] IDLE_TC = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] idle_cnt;
    logic [3:0]  sh_hr_t, sh_hr_o, sh_min_t, sh_min_o;
    logic [3:0]  hr_inc_t, hr_inc_o, min_inc_t, min_inc_o;

    assign mode  = state;
    assign sec_t = 4'd0;
    assign sec_o = 4'd0;

    always_comb begin
        hr_inc_t = hr_t;
        hr_inc_o = hr_o + 4'd1;
        if (hr_t == 4'd2 && hr_o == 4'd3) begin
            hr_inc_t = 4'd0;
            hr_inc_o = 4'd0;
        end else if (hr_o == 4'd9) begin
            hr_inc_t = hr_t + 4'd1;
            hr_inc_o = 4'd0;
        end
    end

    // Minutes wrap 59 -> 00 without touching hours.
    always_comb begin
        min_inc_t = min_t;
        min_inc_o = min_o + 4'd1;
        if (min_o == 4'd9) begin
            min_inc_o = 4'd0;
            min_inc_t = (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idle_cnt <= 16'd0;
            hr_t     <= 4'd0;
            hr_o     <= 4'd0;
            min_t    <= 4'd0;
            min_o    <= 4'd0;
            sh_hr_t  <= 4'd0;
            sh_hr_o  <= 4'd0;
            sh_min_t <= 4'd0;
            sh_min_o <= 4'd0;
            time_ow  <= 1'b0;
            alarm_ld <= 1'b0;
        end else begin
            time_ow  <= 1'b0;
            alarm_ld <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= 16'd0;
                    if (btn_mode) begin
                        state <= T_HR;
                        hr_t  <= cur_hr_t;
                        hr_o  <= cur_hr_o;
                        min_t <= cur_min_t;
                        min_o <= cur_min_o;
                    end else if (btn_alarm) begin
                        state <= A_HR;
                        hr_t  <= sh_hr_t;
                        hr_o  <= sh_hr_o;
                        min_t <= sh_min_t;
                        min_o <= sh_min_o;
                    end
                end
                T_HR, T_MIN, A_HR, A_MIN: begin
                    if (btn_mode) begin
                        idle_cnt <= 16'd0;
                        case (state)
                            T_HR:    state <= T_MIN;
                            A_HR:    state <= A_MIN;
                            T_MIN: begin
                                state   <= IDLE;
                                time_ow <= 1'b1;
                            end
                            default: begin
                                state    <= IDLE;
                                alarm_ld <= 1'b1;
                                sh_hr_t  <= hr_t;
                                sh_hr_o  <= hr_o;
                                sh_min_t <= min_t;
                                sh_min_o <= min_o;
                            end
                        endcase
                    end else if (btn_inc) begin
                        idle_cnt <= 16'd0;
                        if (state == T_HR || state == A_HR) begin
                            hr_t <= hr_inc_t;
                            hr_o <= hr_inc_o;
                        end else begin
                            min_t <= min_inc_t;
                            min_o <= min_inc_o;
                        end
                    end else if (idle_cnt == IDLE_TC) begin
                        // Abandon the edit silently; the shadow is left as it was.
                        state    <= IDLE;
                        idle_cnt <= 16'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    idle_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios then random buttons, all checked
// against an integer hours/minutes model of the setting rules.
module tb_clock_set_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_alarm = 1'b0;
    logic [3:0] cur_hr_t = 4'd0, cur_hr_o = 4'd0, cur_min_t = 4'd0, cur_min_o = 4'd0;
    logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
    logic       time_ow, alarm_ld;
    logic [2:0] mode;

    clock_set_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
        .cur_hr_t(cur_hr_t), .cur_hr_o(cur_hr_o),
        .cur_min_t(cur_min_t), .cur_min_o(cur_min_o),
        .hr_t(hr_t), .hr_o(hr_o), .min_t(min_t), .min_o(min_o),
        .sec_t(sec_t), .sec_o(sec_o),
        .time_ow(time_ow), .alarm_ld(alarm_ld), .mode(mode)
    );

    always #5 clk = ~clk;

    // Reference model: edit value and shadow as plain integer hours/minutes.
    int st, eh, em, sh, sm, quiet;
    bit tow, ald;
    int nvec = 0, nerr = 0;
    int cur_h = 0, cur_m = 0;

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        st = 0; eh = 0; em = 0; sh = 0; sm = 0; quiet = 0; tow = 0; ald = 0;
    endtask

    task automatic set_cur(input int h, input int m);
        cur_h = h; cur_m = m;
        cur_hr_t = 4'(h / 10); cur_hr_o = 4'(h % 10);
        cur_min_t = 4'(m / 10); cur_min_o = 4'(m % 10);
    endtask

    task automatic model_edge(input bit m, input bit i, input bit a);
        tow = 0; ald = 0;
        if (st == 0) begin
            if (m) begin st = 1; eh = cur_h; em = cur_m; end
            else if (a) begin st = 3; eh = sh; em = sm; end
            quiet = 0;
        end else if (m) begin
            quiet = 0;
            if (st == 1) st = 2;
            else if (st == 3) st = 4;
            else if (st == 2) begin st = 0; tow = 1; end
            else begin st = 0; ald = 1; sh = eh; sm = em; end
        end else if (i) begin
            quiet = 0;
            if (st == 1 || st == 3) eh = (eh + 1) % 24;
            else em = (em + 1) % 60;
        end else if (quiet == TO - 1) begin
            st = 0; quiet = 0;
        end else begin
            quiet++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mode"}, int'(mode), st);
        check({tag, ".hr_t"}, int'(hr_t), eh / 10);
        check({tag, ".hr_o"}, int'(hr_o), eh % 10);
        check({tag, ".min_t"}, int'(min_t), em / 10);
        check({tag, ".min_o"}, int'(min_o), em % 10);
        check({tag, ".sec"}, int'({sec_t, sec_o}), 0);
        check({tag, ".time_ow"}, int'(time_ow), int'(tow));
        check({tag, ".alarm_ld"}, int'(alarm_ld), int'(ald));
        check({tag, ".excl"}, int'(time_ow & alarm_ld), 0);
    endtask

    task automatic step(input string tag, input bit m, input bit i, input bit a);
        btn_mode = m; btn_inc = i; btn_alarm = a;
        @(posedge clk);
        model_edge(m, i, a);
        #1;
        btn_mode = 0; btn_inc = 0; btn_alarm = 0;
        check_all(tag);
    endtask

    task automatic bus_is(input string tag, input int h, input int m);
        check({tag, ".bus_h"}, int'(hr_t) * 10 + int'(hr_o), h);
        check({tag, ".bus_m"}, int'(min_t) * 10 + int'(min_o), m);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst_n = 1;
        @(negedge clk);

        // Time set from 23:31.
        set_cur(23, 31);
        step("ts_mode", 1, 0, 0);
        step("ts_inc", 0, 1, 0);
        step("ts_mode2", 1, 0, 0);
        step("ts_inc2", 0, 1, 0);
        step("ts_inc3", 0, 1, 0);
        step("ts_commit", 1, 0, 0);
        check("ts_strobe", int'(time_ow), 1);
        bus_is("ts", 0, 33);
        step("ts_after", 0, 0, 0);
        check("ts_strobe_off", int'(time_ow), 0);
        check("ts_mode0", int'(mode), 0);

        // Alarm set to 07:03, then re-entry reloads it.
        step("al_enter", 0, 0, 1);
        for (int k = 0; k < 7; k++) step("al_inc_h", 0, 1, 0);
        step("al_mode", 1, 0, 0);
        for (int k = 0; k < 3; k++) step("al_inc_m", 0, 1, 0);
        step("al_commit", 1, 0, 0);
        check("al_strobe", int'(alarm_ld), 1);
        bus_is("al", 7, 3);
        step("al_after", 0, 0, 0);
        set_cur(12, 0);
        step("al_reenter", 0, 0, 1);
        bus_is("al_reload", 7, 3);
        step("al_exit1", 1, 0, 0);
        step("al_exit2", 1, 0, 0);

        // Wraps: 23:59 -> minutes 00, hours 23; hours 23 -> 00; 09 -> 10.
        set_cur(23, 59);
        step("wr_enter", 1, 0, 0);
        step("wr_to_min", 1, 0, 0);
        step("wr_min", 0, 1, 0);
        bus_is("wr_min", 23, 0);
        step("wr_commit", 1, 0, 0);
        step("wr_idle", 0, 0, 0);
        step("wr_enter2", 1, 0, 0);
        step("wr_hr", 0, 1, 0);
        bus_is("wr_hr", 0, 59);
        step("wr_commit_a", 1, 0, 0);
        step("wr_commit_b", 1, 0, 0);
        set_cur(9, 15);
        step("wr_enter3", 1, 0, 0);
        step("wr_hr9", 0, 1, 0);
        bus_is("wr_hr9", 10, 15);

        // Timeout from T_HR: 8 idle edges, no strobe. Starts with mode+alarm in IDLE.
        step("to_exit", 1, 0, 0);
        step("to_exit2", 1, 0, 0);
        step("sim_ma", 1, 0, 1);
        check("sim_ma_thr", int'(mode), 1);
        for (int k = 0; k < TO - 1; k++) begin
            step("to_wait", 0, 0, 0);
            check("to_still", int'(mode), 1);
        end
        step("to_fire", 0, 0, 0);
        check("to_idle", int'(mode), 0);
        check("to_no_ow", int'(time_ow), 0);

        // mode+inc in T_HR advances without incrementing.
        set_cur(5, 40);
        step("sim_enter", 1, 0, 0);
        step("sim_mi", 1, 1, 0);
        check("sim_mi_tmin", int'(mode), 2);
        bus_is("sim_mi", 5, 40);
        step("sim_alarm_ign", 0, 0, 1);
        step("sim_exit", 1, 0, 0);

        // Reset during A_MIN discards edit and shadow.
        step("rs_enter", 0, 0, 1);
        step("rs_inc", 0, 1, 0);
        step("rs_amin", 1, 0, 0);
        step("rs_inc2", 0, 1, 0);
        do_reset();
        bus_is("rs", 0, 0);
        step("rs_reenter", 0, 0, 1);
        bus_is("rs_shadow", 0, 0);
        step("rs_out1", 1, 0, 0);
        step("rs_out2", 1, 0, 0);

        // Random buttons with occasional long quiet periods and resets.
        for (int n = 0; n < 1500; n++) begin
            int r;
            if ($urandom_range(0, 9) == 0)
                set_cur($urandom_range(0, 23), $urandom_range(0, 59));
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset();
            end else if (r < 8) begin
                int len = $urandom_range(1, TO + 3);
                for (int k = 0; k < len; k++) step("rnd_quiet", 0, 0, 0);
            end else begin
                step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 4) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
